// File: rtl/stream_pkt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : stream_pkt_arbiter
//  Description : Packet-granular round-robin arbiter placed in front of a
//                stream upsizer. It grants one narrow source at a time and
//                holds the grant until that source's last beat is accepted.
//                Each output beat is tagged with its source index, and packets
//                longer than MAX_BEATS are cut with a forced last.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_pkt_arbiter #(
    parameter int T_DATA_WIDTH = 8,
    parameter int N_SRC        = 4,
    parameter int MAX_BEATS    = 64,
    parameter int ID_W         = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_SRC*T_DATA_WIDTH-1:0] s_data_i,
    input  logic [N_SRC-1:0]              s_last_i,
    input  logic [N_SRC-1:0]              s_valid_i,
    output logic [N_SRC-1:0]              s_ready_o,
    input  logic [N_SRC-1:0]              src_en_i,
    output logic [T_DATA_WIDTH-1:0]       m_data_o,
    output logic                          m_last_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [ID_W-1:0]               m_id_o,
    output logic                          m_trunc_o,
    output logic                          busy_o
);

    localparam int                c_cnt_w    = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MAX_BEATS - 1);
    localparam logic [ID_W-1:0]    c_last_id  = ID_W'(N_SRC - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [ID_W-1:0]          r_gnt;
    logic [ID_W-1:0]          r_rr_ptr;
    logic [c_cnt_w-1:0]       r_beat_cnt;

    logic [T_DATA_WIDTH-1:0]  r_m_data;
    logic                     r_m_last;
    logic                     r_m_valid;
    logic [ID_W-1:0]          r_m_id;
    logic                     r_m_trunc;

    logic [T_DATA_WIDTH-1:0]  w_src_data [N_SRC];
    logic [N_SRC-1:0]         w_req;
    logic                     w_pick_found;
    logic [ID_W-1:0]          w_pick;
    logic                     w_in_grant;
    logic                     w_fwd_ok;
    logic                     w_sel_valid;
    logic                     w_sel_last;
    logic [T_DATA_WIDTH-1:0]  w_sel_data;
    logic                     w_accept;
    logic                     w_cnt_max;
    logic                     w_beat_last;

    // Split the flat source data bus into one lane per source
    generate
        for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
            assign w_src_data[g] = s_data_i[g*T_DATA_WIDTH +: T_DATA_WIDTH];
        end
    endgenerate

    assign w_req       = s_valid_i & src_en_i;
    assign w_in_grant  = (r_state == GRANT);
    // The output register can take a beat when empty or draining this cycle
    assign w_fwd_ok    = !r_m_valid || m_ready_i;
    assign w_sel_valid = s_valid_i[r_gnt];
    assign w_sel_last  = s_last_i[r_gnt];
    assign w_sel_data  = w_src_data[r_gnt];
    assign w_accept    = w_in_grant && w_sel_valid && w_fwd_ok;
    assign w_cnt_max   = (r_beat_cnt == c_cnt_last);
    assign w_beat_last = w_sel_last || w_cnt_max;

    // Round-robin pick: first requester at or above the pointer, else wrap to the lowest
    always_comb begin
        w_pick_found = 1'b0;
        w_pick       = r_rr_ptr;
        for (int i = 0; i < N_SRC; i++) begin
            if (!w_pick_found && w_req[i] && (i >= int'(r_rr_ptr))) begin
                w_pick_found = 1'b1;
                w_pick       = ID_W'(i);
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (!w_pick_found && w_req[i]) begin
                w_pick_found = 1'b1;
                w_pick       = ID_W'(i);
            end
        end
    end

    // Only the granted lane sees ready; it depends on m_ready_i but never on s_valid_i
    always_comb begin
        s_ready_o = '0;
        if (w_in_grant) begin
            s_ready_o[r_gnt] = w_fwd_ok;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: arbitrate in IDLE, release the grant on the accepted last beat
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_req) w_state_nxt = GRANT;
            GRANT:   if (w_accept && w_beat_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant index, round-robin pointer and per-grant beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt      <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else if (r_state == IDLE) begin
            if (|w_req) begin
                r_gnt      <= w_pick;
                r_beat_cnt <= '0;
            end
        end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
            if (w_beat_last) begin
                r_rr_ptr <= (r_gnt == c_last_id) ? '0 : r_gnt + ID_W'(1);
            end
        end
    end

    // Output register: load on accept, otherwise clear valid once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_id    <= '0;
            r_m_trunc <= 1'b0;
        end else if (w_accept) begin
            r_m_data  <= w_sel_data;
            r_m_last  <= w_beat_last;
            r_m_valid <= 1'b1;
            r_m_id    <= r_gnt;
            r_m_trunc <= !w_sel_last && w_cnt_max;
        end else if (r_m_valid && m_ready_i) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_data_o  = r_m_data;
    assign m_last_o  = r_m_last;
    assign m_valid_o = r_m_valid;
    assign m_id_o    = r_m_id;
    assign m_trunc_o = r_m_trunc;
    assign busy_o    = w_in_grant;

endmodule
`default_nettype wire

// File: tb/tb_stream_pkt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_pkt_arbiter
//  Description : Self-checking bench for stream_pkt_arbiter. Sources are
//                packet queues; a cycle-level reference model built from the
//                arbitration rules predicts every output, and a per-source
//                scoreboard checks delivered data order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_pkt_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MAXB = 4;
    localparam int IW   = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] s_data = '0;
    logic [N-1:0]   s_last = '0;
    logic [N-1:0]   s_valid = '0;
    logic [N-1:0]   s_ready;
    logic [N-1:0]   src_en = '0;
    logic [W-1:0]   m_data;
    logic           m_last;
    logic           m_valid;
    logic           m_ready = 1'b0;
    logic [IW-1:0]  m_id;
    logic           m_trunc;
    logic           busy;

    stream_pkt_arbiter #(
        .T_DATA_WIDTH (W),
        .N_SRC        (N),
        .MAX_BEATS    (MAXB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .src_en_i  (src_en),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_id_o    (m_id),
        .m_trunc_o (m_trunc),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    // Source packet queues {last, data} and expected delivery per source
    logic [8:0] srcq [N][$];
    logic [7:0] rxq  [N][$];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit         md_busy;
    int         md_gnt, md_ptr, md_cnt;
    bit         me_valid, me_last, me_trunc;
    logic [7:0] me_data;
    int         me_id;

    // Stimulus controls
    int         ready_mode;   // 0: always ready, 1: random, 2: pattern
    int         gate_pct;     // chance a non-empty source presents valid
    int         bp_idx;
    logic [N-1:0] en_val;
    bit         bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        md_busy = 0; md_gnt = 0; md_ptr = 0; md_cnt = 0;
        me_valid = 0; me_last = 0; me_trunc = 0; me_data = '0; me_id = 0;
    endtask

    task automatic push_pkt(input int src, input int len, input int base, input bit rnd);
        logic [7:0] d;
        for (int b = 0; b < len; b++) begin
            d = rnd ? 8'($urandom) : 8'(base + b);
            srcq[src].push_back({(b == len - 1), d});
            rxq[src].push_back(d);
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0 && $urandom_range(99) < gate_pct) begin
                s_valid[i]       = 1'b1;
                s_data[i*W +: W] = srcq[i][0][7:0];
                s_last[i]        = srcq[i][0][8];
            end else begin
                s_valid[i]       = 1'b0;
                s_data[i*W +: W] = 8'($urandom);
                s_last[i]        = 1'($urandom);
            end
        end
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(1));
            default: begin m_ready = bp_pat[bp_idx % 4]; bp_idx++; end
        endcase
        src_en = en_val;
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_ready;
        int id;
        exp_ready = '0;
        if (md_busy) exp_ready[md_gnt] = (!me_valid || m_ready);
        chk("busy", 32'(busy), 32'(md_busy));
        chk("s_ready", 32'(s_ready), 32'(exp_ready));
        chk("m_valid", 32'(m_valid), 32'(me_valid));
        if (me_valid) begin
            chk("m_data", 32'(m_data), 32'(me_data));
            chk("m_id", 32'(m_id), 32'(me_id));
            chk("m_last", 32'(m_last), 32'(me_last));
            chk("m_trunc", 32'(m_trunc), 32'(me_trunc));
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if ($isunknown(m_id)) begin
                chk("rx_id_known", 32'(m_id), 32'(0));
            end else begin
                id = int'(m_id);
                if (rxq[id].size() == 0) chk("rx_unexpected_beat", 32'(id), 32'hFFFF);
                else                     chk("rx_data_order", 32'(m_data), 32'(rxq[id].pop_front()));
            end
        end
    endtask

    // One clock of the reference model, from the inputs currently driven
    task automatic model_step();
        bit sr, lst, found;
        int idx;
        sr = md_busy && (!me_valid || m_ready);
        if (!md_busy) begin
            if (me_valid && m_ready) me_valid = 0;
            found = 0;
            for (int k = 0; k < N; k++) begin
                idx = (md_ptr + k) % N;
                if (!found && s_valid[idx] && src_en[idx]) begin
                    found = 1; md_busy = 1; md_gnt = idx; md_cnt = 0;
                end
            end
        end else if (s_valid[md_gnt] && sr) begin
            lst      = s_last[md_gnt] || (md_cnt == MAXB - 1);
            me_trunc = !s_last[md_gnt] && (md_cnt == MAXB - 1);
            me_last  = lst;
            me_data  = s_data[md_gnt*W +: W];
            me_id    = md_gnt;
            me_valid = 1;
            md_cnt++;
            void'(srcq[md_gnt].pop_front());
            if (lst) begin
                md_busy = 0;
                md_ptr  = (md_gnt + 1) % N;
            end
        end else if (me_valid && m_ready) begin
            me_valid = 0;
        end
    endtask

    task automatic do_cycle();
        apply_inputs();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit drained();
        bit d;
        d = !md_busy && !me_valid;
        for (int i = 0; i < N; i++)
            if (en_val[i] && srcq[i].size() != 0) d = 0;
        return d;
    endfunction

    task automatic drain(input string tag, input int bound);
        int g;
        g = 0;
        while (!drained() && g < bound) begin do_cycle(); g++; end
        chk(tag, 32'(g < bound), 32'(1));
    endtask

    initial begin
        int first, guard, pk;
        bit new_pkt;
        logic [11:0] obsq [$];
        int idq [$];

        model_reset();
        ready_mode = 0; gate_pct = 100; bp_idx = 0; en_val = '1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_last",  32'(m_last), 0);
        chk("rst_m_trunc", 32'(m_trunc), 0);
        chk("rst_m_id",    32'(m_id), 0);
        chk("rst_m_data",  32'(m_data), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_busy",    32'(busy), 0);
        rst_n = 1'b1;

        // Single source: src 2 sends 0x11,0x22,0x33
        push_pkt(2, 3, 8'h11, 0);
        srcq[2][1][7:0] = 8'h22; rxq[2][1] = 8'h22;
        srcq[2][2][7:0] = 8'h33; rxq[2][2] = 8'h33;
        first = -1;
        for (int k = 0; k < 10; k++) begin
            if (m_valid === 1'b1 && first < 0) first = k;
            do_cycle();
        end
        chk("first_beat_latency", 32'(first), 32'(2));

        // Round robin: every source has three 2-beat packets; pointer starts at 3
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < N; s++) push_pkt(s, 2, s * 16 + p * 2, 0);
        pk = 0; new_pkt = 1; guard = 0;
        while (!drained() && guard < 200) begin
            if (m_valid === 1'b1) begin
                if (new_pkt) begin chk("rr_order", 32'(m_id), 32'((3 + pk) % N)); pk++; end
                new_pkt = m_last;
            end
            do_cycle(); guard++;
        end
        chk("rr_timeout", 32'(guard < 200), 1);
        if (m_valid === 1'b1 && new_pkt) begin chk("rr_order", 32'(m_id), 32'((3 + pk) % N)); pk++; end
        chk("rr_packet_count", 32'(pk), 32'(12));

        // Truncation: src 1 sends 6 beats, src 2 competes
        push_pkt(1, 6, 8'hA0, 0);
        push_pkt(2, 2, 8'hB0, 0);
        guard = 0;
        while (!(drained() && m_valid !== 1'b1) && guard < 100) begin
            if (m_valid === 1'b1) obsq.push_back({m_trunc, m_last, m_id, m_data});
            do_cycle(); guard++;
        end
        chk("trunc_timeout", 32'(guard < 100), 1);
        chk("trunc_beats", 32'(obsq.size()), 32'(8));
        if (obsq.size() == 8) begin
            chk("trunc_forced_last", 32'(obsq[3]), 32'({1'b1, 1'b1, 2'd1, 8'hA3}));
            chk("trunc_other_src",   32'(obsq[4]), 32'({1'b0, 1'b0, 2'd2, 8'hB0}));
            chk("trunc_tail_last",   32'(obsq[7]), 32'({1'b0, 1'b1, 2'd1, 8'hA5}));
        end

        // Back-pressure: ready pattern 1,0,0,1 over a 5-beat packet
        ready_mode = 2; bp_idx = 0;
        push_pkt(0, 5, 8'hC0, 0);
        drain("bp_timeout", 200);

        // Enable mask 1010; drop bit 1 inside src 1's second packet
        ready_mode = 0; en_val = 4'b1010;
        for (int p = 0; p < 3; p++)
            for (int s = 0; s < N; s++) push_pkt(s, 3, s * 16 + p * 3, 0);
        new_pkt = 1; guard = 0;
        while (!(drained() && m_valid !== 1'b1) && guard < 200) begin
            if (md_busy && md_gnt == 1 && srcq[1].size() == 5) en_val = 4'b1000;
            if (m_valid === 1'b1) begin
                if (new_pkt) idq.push_back(int'(m_id));
                new_pkt = m_last;
            end
            do_cycle(); guard++;
        end
        chk("en_timeout", 32'(guard < 200), 1);
        chk("en_grant_count", 32'(idq.size()), 32'(5));
        if (idq.size() == 5) begin
            chk("en_order0", 32'(idq[0]), 1);
            chk("en_order1", 32'(idq[1]), 3);
            chk("en_order2", 32'(idq[2]), 1);
            chk("en_order3", 32'(idq[3]), 3);
            chk("en_order4", 32'(idq[4]), 3);
        end
        chk("en_src1_left", 32'(srcq[1].size()), 32'(3));
        for (int s = 0; s < 3; s++) begin srcq[s].delete(); rxq[s].delete(); end
        en_val = '1;

        // Randomized traffic, ready, valid gaps and enable mask
        ready_mode = 1; gate_pct = 80;
        for (int r = 0; r < 40; r++) begin
            push_pkt($urandom_range(N - 1), $urandom_range(1, 7), 0, 1);
            if ($urandom_range(3) == 0) en_val = 4'($urandom);
            repeat ($urandom_range(6)) do_cycle();
        end
        en_val = '1;
        drain("rand_timeout", 3000);

        // Async reset in the middle of a src 2 packet
        ready_mode = 0; gate_pct = 100;
        push_pkt(2, 4, 8'hD0, 0);
        guard = 0;
        while (!(md_busy && md_gnt == 2 && md_cnt == 2) && guard < 50) begin do_cycle(); guard++; end
        chk("rst_mid_timeout", 32'(guard < 50), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 32'(m_valid), 0);
        chk("arst_m_last",  32'(m_last), 0);
        chk("arst_m_trunc", 32'(m_trunc), 0);
        chk("arst_m_id",    32'(m_id), 0);
        chk("arst_m_data",  32'(m_data), 0);
        chk("arst_s_ready", 32'(s_ready), 0);
        chk("arst_busy",    32'(busy), 0);
        for (int s = 0; s < N; s++) begin srcq[s].delete(); rxq[s].delete(); end
        s_valid = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_pkt(1, 2, 8'hE0, 0);
        push_pkt(0, 2, 8'hE8, 0);
        push_pkt(3, 2, 8'hF0, 0);
        first = -1; guard = 0;
        while (!(drained() && m_valid !== 1'b1) && guard < 100) begin
            if (m_valid === 1'b1 && first < 0) first = int'(m_id);
            do_cycle(); guard++;
        end
        chk("post_rst_first_id", 32'(first), 0);

        for (int s = 0; s < N; s++) chk("rx_left", 32'(rxq[s].size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_pkt_arbiter.md
# stream_pkt_arbiter

Packet-granular round-robin arbiter that shares one stream upsizer between N_SRC narrow source streams. It sits directly in front of the upsizer's slave port and grants one source at a time. The grant is held until that source's last beat is accepted, so packets from different sources never interleave inside an upsized word. It also tags each output beat with its source index and bounds packet length so that one source cannot monopolise the upsizer.

## Interface
- T_DATA_WIDTH, 8, width of one beat; matches upsizer input width.
- N_SRC, 4, number of requesting source streams (2..16).
- MAX_BEATS, 64, maximum beats per granted packet before forced termination (≥2).
- ID_W, derived, max(1, $clog2(N_SRC)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_data_i  in  N_SRC×T_DATA_WIDTH  per-source beat data.
- s_last_i  in  N_SRC  per-source end-of-packet.
- s_valid_i  in  N_SRC  per-source valid.
- s_ready_o  out  N_SRC  per-source ready; at most one bit set.
- src_en_i  in  N_SRC  source enable mask; disabled sources are never granted.
- m_data_o  out  T_DATA_WIDTH  beat to upsizer.
- m_last_o  out  1  end-of-packet to upsizer (source last or forced).
- m_valid_o  out  1  output valid.
- m_ready_i  in  1  upsizer ready.
- m_id_o  out  ID_W  index of the source that produced the current beat.
- m_trunc_o  out  1  current beat is a forced last (MAX_BEATS reached).
- busy_o  out  1  high while a grant is held (state GRANT).

## Operation
- Two-state FSM: IDLE and GRANT.
- IDLE:
  - Compute req = s_valid_i & src_en_i.
  - If req≠0, select the first set bit at or after rr_ptr, wrapping modulo N_SRC.
  - Register that index into gnt, go to GRANT.
  - s_ready_o = 0.
- GRANT:
  - s_ready_o[gnt] = !m_valid_o | m_ready_i. All other ready bits are 0.
  - A beat is accepted when s_valid_i[gnt] & s_ready_o[gnt].
  - The accepted beat loads the output register: m_data_o, m_id_o=gnt, m_valid_o=1.
  - m_last_o = s_last_i[gnt] | (beat_cnt==MAX_BEATS-1).
  - m_trunc_o = !s_last_i[gnt] & (beat_cnt==MAX_BEATS-1).
- beat_cnt: counter, width $clog2(MAX_BEATS).
  - Cleared on entry to GRANT.
  - Incremented on each accepted beat.
  - Saturation is never reached, because the grant ends at MAX_BEATS-1.
- Grant end: an accepted beat whose registered m_last is 1 → IDLE, rr_ptr ← (gnt+1) mod N_SRC.
  - After a truncation, the remaining beats of that source's packet are arbitrated as a new packet.
- Output register:
  - m_valid_o clears when m_valid_o & m_ready_i and no new beat is accepted in that cycle.
  - Data holds stable while m_valid_o & !m_ready_i (AXI-stream rules).
- src_en_i is sampled only in IDLE. Deasserting the granted source's enable mid-packet does not break the grant.
- A granted source dropping s_valid_i mid-packet is legal; the grant is held (no timeout).
- Reset values: m_valid_o=0, m_last_o=0, m_trunc_o=0, m_id_o=0, m_data_o=0, s_ready_o=0, busy_o=0, state=IDLE, rr_ptr=0, beat_cnt=0.

## Timing
- Arbitration: 1 cycle (IDLE→GRANT).
- First beat latency: a source valid at cycle t (block in IDLE) sees s_ready_o at t+1. The beat appears on m_valid_o at t+2.
- Steady state inside a packet: 1 beat/cycle while m_ready_i=1.
- Packet gap: exactly 1 idle cycle on the source side between the last beat of one packet and the first beat of the next. No gap is required on the master side while the output register drains.
- Back-pressure: m_ready_i=0 with m_valid_o=1 → s_ready_o=0 in the same cycle (combinational from m_ready_i and the registered m_valid_o). No beat is lost or duplicated.
- Simultaneous load and drain: m_valid_o & m_ready_i & new accept → register reloads and m_valid_o stays 1.
- No combinational path from s_valid_i to s_ready_o. One combinational path exists from m_ready_i to s_ready_o.
- Async reset mid-packet:
  - All outputs go to reset values immediately.
  - The partial packet is discarded.
  - The upsizer must be reset on the same rst_n.

## Test plan
- Single source: N_SRC=4, src 2 sends 3 beats 0x11,0x22,0x33 with last on the third, m_ready_i=1 → m_valid_o first high 2 cycles after s_valid_i. Expected m_id_o=2 on all beats, m_last_o only on 0x33, busy_o drops the cycle after.
- Round-robin fairness: all 4 sources continuously send 2-beat packets → grant order 0,1,2,3,0,…. No interleaving within a packet, and 1 source-side idle cycle between packets.
- Truncation: MAX_BEATS=4, src 1 sends a 6-beat packet → beat 4 has m_last_o=1 and m_trunc_o=1. Beats 5–6 form a new packet ending with m_last_o=1 and m_trunc_o=0. If src 2 is also requesting, it is granted between the two parts.
- Back-pressure: toggle m_ready_i 1,0,0,1 during a 5-beat packet → all 5 beats are delivered in order with stable data while stalled. s_ready_o[gnt] is 0 exactly in the cycles where m_valid_o=1 and m_ready_i=0.
- Enable mask: src_en_i=4'b1010 with all sources valid → only sources 1 and 3 are granted, alternating. Clearing bit 1 mid-packet of src 1 still completes that packet.
- Reset mid-packet: assert rst_n=0 after 2 beats of a 4-beat packet → all outputs are 0 immediately. After release, rr_ptr=0, so source 0 is granted first if requesting.
